// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O controller with LED/RGB registers, a
// multiplexed 7-segment scanner and a free-running compare timer.
// All state changes on the falling edge of clk; reset is asynchronous, active-low.
// Optional feature: define MMIO_LZ_BLANK_EN to blank leading-zero digits.
module mmio_io_ctrl #(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV_W = 17,
   parameter int LED_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ce,
   input  logic [31:0]           addr,
   input  logic                  we,
   input  logic [31:0]           din,
   output logic [31:0]           dout,
   output logic [LED_W-1:0]      led,
   output logic [2:0]            led_reg0,
   output logic [2:0]            led_reg1,
   output logic [NUM_DIGITS-1:0] num_csn,
   output logic [6:0]            num_a_g,
   output logic                  irq
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
   // Only the nibbles that reach a digit take part in display and blanking.
   localparam logic [31:0] DISP_MASK = 32'hFFFF_FFFF >> (32 - 4 * NUM_DIGITS);

   localparam logic [15:0] OFF_LED   = 16'hF000;
   localparam logic [15:0] OFF_RGB0  = 16'hF004;
   localparam logic [15:0] OFF_RGB1  = 16'hF008;
   localparam logic [15:0] OFF_NUM   = 16'hF010;
   localparam logic [15:0] OFF_COUNT = 16'hE000;
   localparam logic [15:0] OFF_CMP   = 16'hE004;
   localparam logic [15:0] OFF_CTRL  = 16'hE008;
   localparam logic [15:0] OFF_STAT  = 16'hE00C;

   // The bus carries bytes in reversed lane order in both directions.
   function automatic logic [31:0] swap_lanes(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   // Active-low hex segment patterns, bit 6 = a .. bit 0 = g.
   function automatic logic [6:0] seg_lut(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0000001;
         4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;
         4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;
         4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;
         4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;
         4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;
         4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;
         4'hF: return 7'b0111000;
      endcase
   endfunction

   logic [31:0]           led_q, rgb0_q, rgb1_q, num_q, count_q, cmp_q;
   logic [2:0]            ctrl_q;
   logic                  stat_q;
   logic [SCAN_DIV_W-1:0] div_q;
   logic [IDX_W-1:0]      idx_q;

   logic [15:0] off;
   logic [31:0] wdata;
   logic        wr;
   logic        timer_en;
   logic        match;
   logic        unused_addr_hi;

   assign off            = addr[15:0];
   assign wdata          = swap_lanes(din);
   assign wr             = ce && we;
   assign timer_en       = ctrl_q[0];
   assign match          = (count_q == cmp_q);
   assign unused_addr_hi = ^addr[31:16];

   assign led      = led_q[LED_W-1:0];
   assign led_reg0 = rgb0_q[2:0];
   assign led_reg1 = rgb1_q[2:0];
   assign irq      = stat_q & ctrl_q[2];

   // Plain read/write registers loaded from the bus.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q  <= '0;
         rgb0_q <= '0;
         rgb1_q <= '0;
         num_q  <= '0;
         cmp_q  <= '0;
         ctrl_q <= '0;
      end else if (wr) begin
         case (off)
            OFF_LED:  led_q  <= wdata;
            OFF_RGB0: rgb0_q <= wdata;
            OFF_RGB1: rgb1_q <= wdata;
            OFF_NUM:  num_q  <= wdata;
            OFF_CMP:  cmp_q  <= wdata;
            OFF_CTRL: ctrl_q <= wdata[2:0];
            default:  ;
         endcase
      end
   end

   // Timer counter and sticky match flag; a hardware set beats a same-cycle clear.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         stat_q  <= 1'b0;
      end else begin
         if (wr && off == OFF_COUNT)
            count_q <= wdata;
         else if (timer_en && match && ctrl_q[1])
            count_q <= '0;
         else if (timer_en)
            count_q <= count_q + 32'd1;

         if (timer_en && match)
            stat_q <= 1'b1;
         else if (wr && off == OFF_STAT && wdata[0])
            stat_q <= 1'b0;
      end
   end

   // Scan divider and digit index.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         idx_q <= '0;
      end else begin
         div_q <= div_q + SCAN_DIV_W'(1);
         if (&div_q)
            idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
      end
   end

   logic [31:0]           disp_num;
   logic [IDX_W-1:0]      sel_pos;
   logic [4:0]            nib_shift;
   logic [3:0]            nib;
   logic                  blank;
   logic [NUM_DIGITS-1:0] csn_next;
   logic [6:0]            seg_next;

   // Pick the nibble and select line for the current digit.
   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      disp_num  = num_q & DISP_MASK;
      sel_pos   = IDX_MAX - idx_q;
      nib_shift = 5'({sel_pos, 2'b00});
      nib       = disp_num[nib_shift +: 4];
      csn_next  = ~(NUM_DIGITS'(1) << sel_pos);
`ifdef MMIO_LZ_BLANK_EN
      blank     = (idx_q != IDX_MAX) && ((disp_num >> nib_shift) == 32'd0);
`else
      blank     = 1'b0;
`endif
      seg_next  = blank ? 7'b1111111 : seg_lut(nib);
   end

   // Select and segment lines are registered together so they never skew.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_csn <= '1;
         num_a_g <= 7'b1111111;
      end else begin
         num_csn <= csn_next;
         num_a_g <= seg_next;
      end
   end

   logic [31:0] rdata;

   // Combinational read mux; anything other than a matched read returns zero.
   always_comb begin
      rdata = 32'd0;
      if (ce && !we) begin
         case (off)
            OFF_LED:   rdata = led_q;
            OFF_RGB0:  rdata = rgb0_q;
            OFF_RGB1:  rdata = rgb1_q;
            OFF_NUM:   rdata = num_q;
            OFF_COUNT: rdata = count_q;
            OFF_CMP:   rdata = cmp_q;
            OFF_CTRL:  rdata = {29'd0, ctrl_q};
            OFF_STAT:  rdata = {31'd0, stat_q};
            default:   rdata = 32'd0;
         endcase
      end
   end

   assign dout = swap_lanes(rdata);

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: directed literal checks plus randomized bus traffic
// compared every rising edge against a behavioural model of the controller.
// Define MMIO_LZ_BLANK_EN for both bench and design to exercise blanking.
module tb_mmio_io_ctrl;

   localparam int ND = 4;
   localparam int DW = 2;
   localparam int LW = 16;
   localparam logic [31:0] DMASK = (ND == 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * ND)) - 32'd1);
   localparam logic [6:0] SEG [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          ce = 1'b0;
   logic [31:0]   addr = '0;
   logic          we = 1'b0;
   logic [31:0]   din = '0;
   logic [31:0]   dout;
   logic [LW-1:0] led;
   logic [2:0]    led_reg0, led_reg1;
   logic [ND-1:0] num_csn;
   logic [6:0]    num_a_g;
   logic          irq;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mmio_io_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV_W(DW), .LED_W(LW)) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .addr(addr), .we(we), .din(din),
      .dout(dout), .led(led), .led_reg0(led_reg0), .led_reg1(led_reg1),
      .num_csn(num_csn), .num_a_g(num_a_g), .irq(irq));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] swap(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   // ---------------- behavioural model ----------------
   logic [31:0] m_led = '0, m_rgb0 = '0, m_rgb1 = '0, m_num = '0;
   logic [31:0] m_count = '0, m_cmp = '0, m_shown = '0;
   logic [2:0]  m_ctrl = '0;
   logic        m_stat = 1'b0;
   int          m_edges = 0;   // falling edges since reset

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_led <= '0; m_rgb0 <= '0; m_rgb1 <= '0; m_num <= '0;
         m_count <= '0; m_cmp <= '0; m_ctrl <= '0; m_stat <= 1'b0;
         m_edges <= 0; m_shown <= '0;
      end else begin
         m_edges <= m_edges + 1;
         m_shown <= m_num;
         if (ce && we) begin
            case (addr[15:0])
               16'hF000: m_led  <= swap(din);
               16'hF004: m_rgb0 <= swap(din);
               16'hF008: m_rgb1 <= swap(din);
               16'hF010: m_num  <= swap(din);
               16'hE004: m_cmp  <= swap(din);
               16'hE008: m_ctrl <= swap(din) & 32'd7;
               default: ;
            endcase
         end
         if (ce && we && addr[15:0] == 16'hE000) m_count <= swap(din);
         else if (m_ctrl[0] && m_count == m_cmp && m_ctrl[1]) m_count <= '0;
         else if (m_ctrl[0]) m_count <= m_count + 1;
         if (m_ctrl[0] && m_count == m_cmp) m_stat <= 1'b1;
         else if (ce && we && addr[15:0] == 16'hE00C && swap(din) & 32'd1) m_stat <= 1'b0;
      end
   end

   // Digit shown after n edges: the one the scan held during edge n-1.
   function automatic int shown_digit();
      return ((m_edges - 1) / (1 << DW)) % ND;
   endfunction

   function automatic logic [31:0] exp_csn();
      logic [31:0] v;
      int d;
      v = '0;
      if (m_edges == 0) return 32'((1 << ND) - 1);
      d = shown_digit();
      for (int b = 0; b < ND; b++) v[b] = (b != ND - 1 - d);
      return v;
   endfunction

   function automatic logic [31:0] exp_seg();
      int d;
      logic [31:0] upper;
      if (m_edges == 0) return 32'h7F;
      d = shown_digit();
      upper = (m_shown & DMASK) >> (4 * (ND - 1 - d));
`ifdef MMIO_LZ_BLANK_EN
      if (d != ND - 1 && upper == 0) return 32'h7F;
`endif
      return 32'(SEG[upper[3:0]]);
   endfunction

   function automatic logic [31:0] exp_dout();
      logic [31:0] v;
      v = '0;
      if (ce && !we) begin
         case (addr[15:0])
            16'hF000: v = m_led;
            16'hF004: v = m_rgb0;
            16'hF008: v = m_rgb1;
            16'hF010: v = m_num;
            16'hE000: v = m_count;
            16'hE004: v = m_cmp;
            16'hE008: v = 32'(m_ctrl);
            16'hE00C: v = 32'(m_stat);
            default:  v = '0;
         endcase
      end
      return swap(v);
   endfunction

   // Compare process: outputs are stable on the rising edge.
   always @(posedge clk) begin
      if (rst_n) begin
         check("led",  32'(led),      32'(m_led[LW-1:0]));
         check("rgb0", 32'(led_reg0), 32'(m_rgb0[2:0]));
         check("rgb1", 32'(led_reg1), 32'(m_rgb1[2:0]));
         check("csn",  32'(num_csn),  exp_csn());
         check("seg",  32'(num_a_g),  exp_seg());
         check("irq",  32'(irq),      32'(m_stat & m_ctrl[2]));
         check("dout", dout,          exp_dout());
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      ce = 1'b1; we = 1'b1; addr = {16'h0000, a}; din = d;
      @(negedge clk); #1;
      ce = 1'b0; we = 1'b0; din = '0;
   endtask

   task automatic set_read(input logic [15:0] a);
      ce = 1'b1; we = 1'b0; addr = {16'h0000, a};
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); #1;
      end
   endtask

   logic [ND-1:0] csn_tab [4] = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};
   logic [6:0]    seg_tab [4] = '{7'b0010010, 7'b0000110, 7'b1001100, 7'b1001111};
   logic [6:0]    lz_seg;

   initial begin
      logic [15:0] offs [10] = '{16'hF000, 16'hF004, 16'hF008, 16'hF010, 16'hE000,
                                 16'hE004, 16'hE008, 16'hE00C, 16'hF014, 16'h0000};
      int sel;
      logic [31:0] v;

      // Reset values.
      #1 rst_n = 1'b0;
      #1;
      set_read(16'hE000);
      check("rst_led", 32'(led), 32'h0);
      check("rst_csn", 32'(num_csn), 32'hF);
      check("rst_seg", 32'(num_a_g), 32'h7F);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_count", dout, 32'h0);
      ce = 1'b0;
      @(posedge clk); #2 rst_n = 1'b1;

      // LED write and readback.
      bus_write(16'hF000, 32'h3412_0000);
      check("led_1234", 32'(led), 32'h1234);
      set_read(16'hF000);
      check("rd_led", dout, 32'h3412_0000);
      set_read(16'hF014);
      check("rd_unmapped", dout, 32'h0);

      // Timer with auto-clear and interrupt.
      bus_write(16'hE004, 32'h0500_0000);
      bus_write(16'hE008, 32'h0700_0000);
      set_read(16'hE000);
      check("count0", dout, 32'h0);
      for (int k = 1; k <= 5; k++) begin
         steps(1);
         check("count_run", dout, 32'(k) << 24);
         check("irq_low", 32'(irq), 32'h0);
      end
      steps(1);
      check("count_clear", dout, 32'h0);
      check("irq_rise", 32'(irq), 32'h1);
      bus_write(16'hE00C, 32'h0100_0000);
      check("irq_w1c", 32'(irq), 32'h0);
      set_read(16'hE000);
      check("count_after_w1c", dout, 32'h0100_0000);
      steps(4);
      check("count5", dout, 32'h0500_0000);

      // Clear lands on the same cycle as a match: the set must win.
      bus_write(16'hE00C, 32'h0100_0000);
      check("irq_set_wins", 32'(irq), 32'h1);
      set_read(16'hE00C);
      check("stat_set_wins", dout, 32'h0100_0000);

      // Asynchronous reset while irq is high.
      addr = 32'h0000_E000;
      rst_n = 1'b0;
      #1;
      check("arst_led", 32'(led), 32'h0);
      check("arst_csn", 32'(num_csn), 32'hF);
      check("arst_seg", 32'(num_a_g), 32'h7F);
      check("arst_irq", 32'(irq), 32'h0);
      check("arst_count", dout, 32'h0);
      ce = 1'b0;
      @(posedge clk); #2 rst_n = 1'b1;

      // Scan sequence: NUM written at edge 2, table covers edges 5..20.
      bus_write(16'hF010, swap(32'h0000_1234));
      steps(2);
      for (int j = 0; j < 16; j++) begin
         steps(1);
         check("scan_csn", 32'(num_csn), 32'(csn_tab[j / 4]));
         check("scan_seg", 32'(num_a_g), 32'(seg_tab[j / 4]));
      end

      // Leading zeros: NUM=7 written at edge 21.
`ifdef MMIO_LZ_BLANK_EN
      lz_seg = 7'b1111111;
`else
      lz_seg = 7'b0000001;
`endif
      bus_write(16'hF010, swap(32'h0000_0007));
      steps(1);
      check("lz_d1_csn", 32'(num_csn), 32'b1011);
      check("lz_d1_seg", 32'(num_a_g), 32'(lz_seg));
      steps(3);
      check("lz_d2_csn", 32'(num_csn), 32'b1101);
      check("lz_d2_seg", 32'(num_a_g), 32'(lz_seg));
      steps(4);
      check("lz_d3_csn", 32'(num_csn), 32'b1110);
      check("lz_d3_seg", 32'(num_a_g), 32'b0001111);
      steps(4);
      check("lz_d0_csn", 32'(num_csn), 32'b0111);
      check("lz_d0_seg", 32'(num_a_g), 32'(lz_seg));
      bus_write(16'hF010, 32'h0);
      steps(11);
      check("zero_d3_csn", 32'(num_csn), 32'b1110);
      check("zero_d3_seg", 32'(num_a_g), 32'b0000001);

      // Randomized traffic, checked by the compare process every cycle.
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         sel  = $urandom_range(0, 9);
         addr = {16'($urandom), offs[sel]};
         ce   = ($urandom_range(0, 3) != 0);
         we   = $urandom_range(0, 1) == 1;
         case (offs[sel])
            16'hE000, 16'hE004: v = 32'($urandom_range(0, 12));
            16'hE008:           v = 32'($urandom_range(0, 7)) | 32'(($urandom_range(0, 3) != 0));
            16'hE00C:           v = 32'($urandom_range(0, 1));
            default:            v = $urandom;
         endcase
         din = swap(v);
      end
      @(posedge clk); #1;
      ce = 1'b0; we = 1'b0;
      steps(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
